// File: rtl/snn_pkg.sv
// Shared constants and state type for the SNN frame sequencer.
// Optional watchdog: SNN_FRAME_CTRL_TIMEOUT_EN.
package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = 98;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    LOAD,
    KICK,
    RUN,
    SEND,
    DRAIN
  } frame_state_t;

endpackage

// File: rtl/snn_frame_ctrl_if.sv
// UART-side byte handshake between the UART wrapper and the sequencer.
// master: sequencer view, slave: UART wrapper view.
interface snn_frame_ctrl_if;

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_rdy,
    input  rx_data,
    input  tx_busy,
    output tx_start,
    output tx_data
  );

  modport slave (
    output rx_rdy,
    output rx_data,
    output tx_busy,
    input  tx_start,
    input  tx_data
  );

endinterface

// File: rtl/pixel_buf.sv
// 784x1 pixel bit buffer: byte-wide writes, registered 1-bit reads.
// Out-of-range reads return 0.
module pixel_buf
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [6:0] wr_byte_addr,
  input  logic [7:0] wr_data,
  input  logic [9:0] rd_addr,
  output logic       rd_q
);

  logic [7:0] mem [NUM_BYTES];

  // Storage is not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_byte_addr < 7'(NUM_BYTES)))
      mem[wr_byte_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_q <= 1'b0;
    else if (rd_addr < 10'(NUM_PIXELS))
      rd_q <= mem[rd_addr[9:3]][rd_addr[2:0]];
    else
      rd_q <= 1'b0;
  end

endmodule

// File: rtl/snn_frame_ctrl.sv
// Per-frame sequencer: load 98 bytes, start snn_core, send digit as ASCII.
// Optional RUN watchdog: define SNN_FRAME_CTRL_TIMEOUT_EN.
module snn_frame_ctrl
  import snn_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snn_frame_ctrl_if.master      uart,
  output logic                  snn_start,
  input  logic                  snn_done,
  input  logic [3:0]            snn_digit,
  input  logic [9:0]            addr_input_unit,
  output logic                  q_input,
  output logic                  busy,
  output logic                  rx_drop
);

  frame_state_t state;
  logic [6:0]   byte_cnt;
  logic [7:0]   tx_data_r;
  logic         drain_wait;
  logic         wr_en;

`ifdef SNN_FRAME_CTRL_TIMEOUT_EN
  logic [31:0]  tmo_cnt;
`else
  wire unused_tmo = |TIMEOUT_CYC;
`endif

  assign wr_en         = (state == LOAD) && uart.rx_rdy;
  assign busy          = (state != LOAD);
  assign snn_start     = (state == KICK);
  assign uart.tx_start = (state == SEND) && !uart.tx_busy;
  assign uart.tx_data  = tx_data_r;

  pixel_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_byte_addr (byte_cnt),
    .wr_data      (uart.rx_data),
    .rd_addr      (addr_input_unit),
    .rd_q         (q_input)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_drop <= 1'b0;
    else if (uart.rx_rdy && (state != LOAD))
      rx_drop <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      byte_cnt   <= 7'd0;
      tx_data_r  <= 8'h00;
      drain_wait <= 1'b0;
`ifdef SNN_FRAME_CTRL_TIMEOUT_EN
      tmo_cnt    <= 32'd0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          if (uart.rx_rdy) begin
            if (byte_cnt == 7'(NUM_BYTES - 1)) begin
              byte_cnt <= 7'd0;
              state    <= KICK;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end
        end
        KICK: begin
`ifdef SNN_FRAME_CTRL_TIMEOUT_EN
          tmo_cnt <= 32'd0;
`endif
          state <= RUN;
        end
        RUN: begin
          // tx_data is loaded here so it is valid with the combinational tx_start
          if (snn_done) begin
            tx_data_r <= ASCII_ZERO + {4'd0, snn_digit};
            state     <= SEND;
          end
`ifdef SNN_FRAME_CTRL_TIMEOUT_EN
          else if (tmo_cnt + 32'd1 >= TIMEOUT_CYC) begin
            tx_data_r <= ASCII_ERR;
            state     <= SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end
        SEND: begin
          if (!uart.tx_busy) begin
            drain_wait <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_wait)
            drain_wait <= 1'b0;
          else if (!uart.tx_busy)
            state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Directed bench for snn_frame_ctrl with table-driven pixel reads.
// Define SNN_FRAME_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_snn_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       snn_start;
  logic       snn_done;
  logic [3:0] snn_digit;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       busy;
  logic       rx_drop;

  int n_cmp;
  int n_err;
  int start_cnt;
  int tx_cnt;
  int cyc;

  snn_frame_ctrl_if u ();

  snn_frame_ctrl #(.TIMEOUT_CYC(32'd100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart            (u.master),
    .snn_start       (snn_start),
    .snn_done        (snn_done),
    .snn_digit       (snn_digit),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .busy            (busy),
    .rx_drop         (rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (snn_start) start_cnt <= start_cnt + 1;
    if (u.tx_start) tx_cnt <= tx_cnt + 1;
  end

  typedef struct {
    logic [9:0] addr;
    logic       exp;
  } rd_vec_t;

  rd_vec_t va5 [8];
  rd_vec_t v0f [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      u.rx_rdy  = 1'b1;
      u.rx_data = b;
      tick();
    end
    u.rx_rdy = 1'b0;
  endtask

  task automatic read_a5(input string tag);
    for (int i = 0; i < 8; i++) begin
      addr_input_unit = va5[i].addr;
      tick();
      @(negedge clk);
      chk($sformatf("%s_px%0d", tag, va5[i].addr), 32'(q_input),
          32'(va5[i].exp));
    end
  endtask

  task automatic read_0f();
    for (int i = 0; i < 6; i++) begin
      addr_input_unit = v0f[i].addr;
      tick();
      @(negedge clk);
      chk($sformatf("f0f_px%0d", v0f[i].addr), 32'(q_input),
          32'(v0f[i].exp));
    end
  endtask

  task automatic done_pulse(input logic [3:0] d);
    snn_digit = d;
    snn_done  = 1'b1;
    tick();
    snn_done  = 1'b0;
    snn_digit = 4'd0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 10 && busy; i++) tick();
    @(negedge clk);
    chk(tag, 32'(busy), 32'd0);
    tick();
  endtask

  int s0;
  int t0;
  int bad;
  int dt;

  initial begin
    n_cmp = 0; n_err = 0;
    start_cnt = 0; tx_cnt = 0; cyc = 0;
    va5[0] = '{10'd0,    1'b1};
    va5[1] = '{10'd1,    1'b0};
    va5[2] = '{10'd2,    1'b1};
    va5[3] = '{10'd5,    1'b1};
    va5[4] = '{10'd6,    1'b0};
    va5[5] = '{10'd783,  1'b1};
    va5[6] = '{10'd784,  1'b0};
    va5[7] = '{10'd1023, 1'b0};
    v0f[0] = '{10'd3,    1'b1};
    v0f[1] = '{10'd4,    1'b0};
    v0f[2] = '{10'd0,    1'b1};
    v0f[3] = '{10'd776,  1'b1};
    v0f[4] = '{10'd780,  1'b0};
    v0f[5] = '{10'd787,  1'b0};

    rst_n = 1'b0;
    u.rx_rdy = 1'b0; u.rx_data = 8'h00; u.tx_busy = 1'b0;
    snn_done = 1'b0; snn_digit = 4'd0; addr_input_unit = 10'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_tx_start", 32'(u.tx_start), 32'd0);
    chk("rst_tx_data", 32'(u.tx_data), 32'd0);
    chk("rst_snn_start", 32'(snn_start), 32'd0);
    chk("rst_q_input", 32'(q_input), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1: all bytes A5
    send_bytes(8'hA5, 98);
    @(negedge clk);
    chk("f1_start_hi", 32'(snn_start), 32'd1);
    chk("f1_busy_kick", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("f1_start_lo", 32'(snn_start), 32'd0);
    chk("f1_busy_run", 32'(busy), 32'd1);
    read_a5("f1");
    chk("f1_start_cnt", 32'(start_cnt), 32'd1);

    // Bytes during RUN are dropped
    send_bytes(8'h00, 3);
    @(negedge clk);
    chk("drop_flag", 32'(rx_drop), 32'd1);
    chk("drop_busy", 32'(busy), 32'd1);
    read_a5("drop");

    done_pulse(4'd7);
    @(negedge clk);
    chk("d7_tx_start", 32'(u.tx_start), 32'd1);
    chk("d7_tx_data", 32'(u.tx_data), 32'h37);
    tick();
    @(negedge clk);
    chk("d7_tx_start_lo", 32'(u.tx_start), 32'd0);
    chk("d7_drain_busy", 32'(busy), 32'd1);
    wait_idle("d7_idle");
    chk("d7_tx_cnt", 32'(tx_cnt), 32'd1);
    chk("d7_tx_hold", 32'(u.tx_data), 32'h37);

    // Stray done in LOAD
    done_pulse(4'd2);
    tick();
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_tx_cnt", 32'(tx_cnt), 32'd1);

    // Frame 2 must need all 98 bytes despite the dropped ones
    send_bytes(8'h3C, 97);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    chk("f2_97_busy", 32'(busy), 32'd0);
    chk("f2_97_starts", 32'(start_cnt), 32'd1);
    tick();
    send_bytes(8'h3C, 1);
    @(negedge clk);
    chk("f2_start_hi", 32'(snn_start), 32'd1);
    tick();

    // TX busy hold at SEND
    u.tx_busy = 1'b1;
    done_pulse(4'd3);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u.tx_start) bad++;
      tick();
    end
    chk("hold_no_tx", 32'(bad), 32'd0);
    u.tx_busy = 1'b0;
    @(negedge clk);
    chk("hold_tx_start", 32'(u.tx_start), 32'd1);
    chk("hold_tx_data", 32'(u.tx_data), 32'h33);
    tick();
    u.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    chk("drain_hold_busy", 32'(busy), 32'd1);
    u.tx_busy = 1'b0;
    tick();
    wait_idle("hold_idle");
    chk("hold_tx_cnt", 32'(tx_cnt), 32'd2);

    // Reset mid-frame
    send_bytes(8'hFF, 40);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rx_drop", 32'(rx_drop), 32'd0);
    chk("mrst_tx_data", 32'(u.tx_data), 32'd0);
    rst_n = 1'b1;
    tick();
    s0 = start_cnt;
    send_bytes(8'h0F, 97);
    @(negedge clk);
    chk("f3_97_busy", 32'(busy), 32'd0);
    tick();
    send_bytes(8'h0F, 1);
    @(negedge clk);
    chk("f3_start_hi", 32'(snn_start), 32'd1);
    tick();
    read_0f();
    chk("f3_one_start", 32'(start_cnt - s0), 32'd1);
    done_pulse(4'd9);
    @(negedge clk);
    chk("d9_tx_data", 32'(u.tx_data), 32'h39);
    tick();
    wait_idle("d9_idle");

`ifdef SNN_FRAME_CTRL_TIMEOUT_EN
    send_bytes(8'h55, 98);
    t0 = cyc;
    dt = -1;
    for (int i = 0; i < 300 && dt < 0; i++) begin
      @(negedge clk);
      if (u.tx_start) dt = cyc - t0;
      else tick();
    end
    chk("tmo_seen", 32'(dt >= 0), 32'd1);
    chk("tmo_lat", 32'(dt >= 95 && dt <= 110), 32'd1);
    chk("tmo_tx_data", 32'(u.tx_data), 32'h3F);
    s0 = tx_cnt;
    tick();
    done_pulse(4'd5);
    for (int i = 0; i < 10; i++) tick();
    chk("tmo_no_second", 32'(tx_cnt - s0), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
`else
    t0 = 0;
    dt = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
